// File: rtl/conv_ifm_feeder_if.sv
// Handshake bundle between the IFM feeder, its nibble source, the convolution core
// and the result consumer.
interface conv_ifm_feeder_if #(
  parameter int unsigned N_ELEM = 32,
  parameter int unsigned DW     = 4,
  parameter int unsigned OW     = 13
);
  logic                   s_valid;
  logic                   s_ready;
  logic [DW-1:0]          s_data;
  logic                   s_last;
  logic                   conv_in_valid;
  logic [N_ELEM*DW-1:0]   conv_ifm;
  logic                   conv_out_valid;
  logic [OW-1:0]          conv_ofm;
  logic                   r_valid;
  logic                   r_ready;
  logic [OW-1:0]          r_data;
  logic                   r_timeout;
  logic                   frame_err;

  // Feeder side
  modport master (
    input  s_valid, s_data, s_last, conv_out_valid, conv_ofm, r_ready,
    output s_ready, conv_in_valid, conv_ifm, r_valid, r_data, r_timeout, frame_err
  );

  // Source / core / consumer side
  modport slave (
    output s_valid, s_data, s_last, conv_out_valid, conv_ofm, r_ready,
    input  s_ready, conv_in_valid, conv_ifm, r_valid, r_data, r_timeout, frame_err
  );
endinterface

// File: rtl/conv_ifm_feeder.sv
// Collects a 32-nibble IFM frame, fires it at the convolution core as a one-cycle
// burst, and returns the core's OFM (or a timeout marker) over valid/ready.
module conv_ifm_feeder #(
  parameter int unsigned N_ELEM  = 32,
  parameter int unsigned DW      = 4,
  parameter int unsigned OW      = 13,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_ifm_feeder_if.master    bus
);

  localparam int unsigned CW = $clog2(N_ELEM);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t                       state_q;
  logic [CW-1:0]                cnt_q;
  logic [TW-1:0]                timer_q;
  logic [N_ELEM-1:0][DW-1:0]    frame_q;
  logic [N_ELEM-1:0][DW-1:0]    frame_c;
  logic                         accept_c;
  logic                         last_slot_c;

  assign accept_c    = (state_q == ST_COLLECT) && bus.s_valid && bus.s_ready;
  assign last_slot_c = (cnt_q == CW'(N_ELEM - 1));

  // Frame buffer with the incoming nibble merged in, so the last beat can issue directly
  always_comb begin
    frame_c        = frame_q;
    frame_c[cnt_q] = bus.s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= ST_COLLECT;
      cnt_q             <= '0;
      timer_q           <= '0;
      frame_q           <= '0;
      bus.s_ready       <= 1'b0;
      bus.conv_in_valid <= 1'b0;
      bus.conv_ifm      <= '0;
      bus.r_valid       <= 1'b0;
      bus.r_data        <= '0;
      bus.r_timeout     <= 1'b0;
      bus.frame_err     <= 1'b0;
    end else begin
      bus.conv_in_valid <= 1'b0;
      bus.frame_err     <= 1'b0;
      unique case (state_q)
        ST_COLLECT: begin
          bus.s_ready <= 1'b1;
          if (accept_c) begin
            if (bus.s_last && last_slot_c) begin
              frame_q           <= frame_c;
              bus.conv_ifm      <= frame_c;
              bus.conv_in_valid <= 1'b1;
              bus.s_ready       <= 1'b0;
              cnt_q             <= '0;
              state_q           <= ST_ISSUE;
            end else if (bus.s_last || last_slot_c) begin
              // Misaligned s_last: drop the partial frame and resynchronise
              cnt_q         <= '0;
              bus.frame_err <= 1'b1;
            end else begin
              frame_q <= frame_c;
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        end
        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.conv_out_valid) begin
            bus.r_data    <= bus.conv_ofm;
            bus.r_timeout <= 1'b0;
            bus.r_valid   <= 1'b1;
            state_q       <= ST_HOLD;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            bus.r_data    <= '0;
            bus.r_timeout <= 1'b1;
            bus.r_valid   <= 1'b1;
            state_q       <= ST_HOLD;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_HOLD: begin
          if (bus.r_ready) begin
            bus.r_valid <= 1'b0;
            bus.s_ready <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ST_COLLECT;
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ifm_feeder.sv
// Bench for conv_ifm_feeder: a behavioural convolution-core stub plus a frame-level
// reference model checking issue timing, packing, results and error handling.
module tb_conv_ifm_feeder;

  localparam int unsigned N_ELEM  = 32;
  localparam int unsigned DW      = 4;
  localparam int unsigned OW      = 13;
  localparam int unsigned TIMEOUT = 8;

  typedef logic [DW-1:0] frame_t [N_ELEM];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_ifm_feeder_if #(.N_ELEM(N_ELEM), .DW(DW), .OW(OW)) bus ();

  conv_ifm_feeder #(.N_ELEM(N_ELEM), .DW(DW), .OW(OW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;
  bit core_en  = 1'b1;
  bit spur_en  = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  // Core tap weights: sum 248, tap 1 = 14
  function automatic int weight(input int k);
    int w;
    w = (5 * k + 9) % 16;
    if (k == 31) w += 8;
    return w;
  endfunction

  function automatic int core_dot(input logic [N_ELEM*DW-1:0] v);
    int s = 0;
    for (int k = 0; k < N_ELEM; k++) s += weight(k) * int'(v[DW*k +: DW]);
    return s;
  endfunction

  function automatic int ref_ofm(input frame_t el);
    int s = 0;
    for (int k = 0; k < N_ELEM; k++) s += weight(k) * int'(el[k]);
    return s;
  endfunction

  function automatic logic [N_ELEM*DW-1:0] ref_pack(input frame_t el);
    logic [N_ELEM*DW-1:0] r;
    for (int k = 0; k < N_ELEM; k++) r[DW*k +: DW] = el[k];
    return r;
  endfunction

  // Two-stage core stub, plus optional junk out_valid pulses the feeder must ignore
  logic st1_v;
  int   st1_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st1_v              <= 1'b0;
      st1_d              <= 0;
      bus.conv_out_valid <= 1'b0;
      bus.conv_ofm       <= '0;
    end else begin
      st1_v <= bus.conv_in_valid && core_en;
      st1_d <= core_dot(bus.conv_ifm);
      if (st1_v) begin
        bus.conv_out_valid <= 1'b1;
        bus.conv_ofm       <= OW'(st1_d);
      end else if (spur_en && (bus.s_ready || bus.r_valid) && $urandom_range(0, 2) == 0) begin
        bus.conv_out_valid <= 1'b1;
        bus.conv_ofm       <= OW'($urandom);
      end else begin
        bus.conv_out_valid <= 1'b0;
        bus.conv_ofm       <= OW'($urandom);
      end
    end
  end

  // Event monitor sampled just after each edge
  int                    civ_count = 0;
  int                    civ_cycle = -1;
  logic [N_ELEM*DW-1:0]  civ_ifm   = '0;
  int                    ferr_count = 0;
  always @(posedge clk) begin
    #2;
    if (bus.conv_in_valid === 1'b1) begin
      civ_count++;
      civ_cycle = cycle;
      civ_ifm   = bus.conv_ifm;
    end
    if (bus.frame_err === 1'b1) ferr_count++;
  end

  // Called at a negedge; returns at the negedge after the final accepted beat
  task automatic send_frame(input frame_t el, input int n_beats, input int last_beat,
                            input bit bubbles, output int acc_cyc);
    int i = 0;
    int guard = 0;
    acc_cyc = -1;
    while (i < n_beats && guard < 1000) begin
      guard++;
      if (bubbles && $urandom_range(0, 3) == 0) begin
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = el[i];
        bus.s_last  = (i == last_beat);
      end
      if (bus.s_valid && bus.s_ready) begin
        i++;
        acc_cyc = cycle + 1;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    n_checks++;
    if (i != n_beats) begin
      n_errors++;
      $display("FAIL send_beats: accepted %0d, required %0d", i, n_beats);
    end
  endtask

  task automatic expect_result(input int acc_cyc, input int exp_data, input bit exp_to,
                               input int exp_lat, input int hold);
    int guard = 0;
    logic [OW-1:0] d0;
    while (bus.r_valid !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (bus.r_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL r_valid_wait: r_valid=%b after %0d cycles, required 1", bus.r_valid, guard);
      return;
    end
    n_checks++;
    if (cycle - acc_cyc !== exp_lat) begin
      n_errors++;
      $display("FAIL r_valid_latency: got %0d edges, required %0d", cycle - acc_cyc, exp_lat);
    end
    n_checks++;
    if (bus.r_data !== OW'(exp_data)) begin
      n_errors++;
      $display("FAIL r_data: got %0d, required %0d", bus.r_data, exp_data);
    end
    n_checks++;
    if (bus.r_timeout !== exp_to || bus.s_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL r_timeout_sready: r_timeout=%b s_ready=%b, required %b 0",
               bus.r_timeout, bus.s_ready, exp_to);
    end
    d0 = bus.r_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      n_checks++;
      if (bus.r_valid !== 1'b1 || bus.r_data !== d0 || bus.s_ready !== 1'b0 ||
          bus.r_timeout !== exp_to) begin
        n_errors++;
        $display("FAIL hold_stable: r_valid=%b r_data=%0d s_ready=%b, required 1 %0d 0",
                 bus.r_valid, bus.r_data, bus.s_ready, d0);
      end
    end
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    n_checks++;
    if (bus.r_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL release: r_valid=%b s_ready=%b, required 0 1", bus.r_valid, bus.s_ready);
    end
  endtask

  task automatic run_frame(input frame_t el, input bit to, input int hold, input bit bubbles,
                           output int acc);
    int c0 = civ_count;
    send_frame(el, N_ELEM, N_ELEM - 1, bubbles, acc);
    expect_result(acc, to ? 0 : ref_ofm(el), to, to ? 1 + TIMEOUT : 3, hold);
    n_checks++;
    if (civ_count - c0 !== 1 || civ_cycle !== acc) begin
      n_errors++;
      $display("FAIL issue_pulse: %0d pulses at edge %0d, required 1 at edge %0d",
               civ_count - c0, civ_cycle, acc);
    end
    n_checks++;
    if (civ_ifm !== ref_pack(el) || bus.conv_ifm !== ref_pack(el)) begin
      n_errors++;
      $display("FAIL conv_ifm: got %h, required %h", civ_ifm, ref_pack(el));
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if (bus.s_ready !== 1'b0 || bus.conv_in_valid !== 1'b0 || bus.conv_ifm !== '0 ||
        bus.r_valid !== 1'b0 || bus.r_data !== '0 || bus.r_timeout !== 1'b0 ||
        bus.frame_err !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: s_ready=%b civ=%b ifm=%h r_valid=%b r_data=%0d r_to=%b ferr=%b, required all 0",
               tag, bus.s_ready, bus.conv_in_valid, bus.conv_ifm, bus.r_valid, bus.r_data,
               bus.r_timeout, bus.frame_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    rst_n = 1'b1;
    n_checks++;
    if (bus.s_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL s_ready_before_edge: got %b, required 0", bus.s_ready);
    end
    @(negedge clk);
    n_checks++;
    if (bus.s_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL s_ready_after_edge: got %b, required 1", bus.s_ready);
    end
  endtask

  task automatic test_patterns();
    frame_t el;
    int acc;
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'd1;
    run_frame(el, 1'b0, 0, 1'b0, acc);
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'd15;
    run_frame(el, 1'b0, 0, 1'b0, acc);
    for (int k = 0; k < N_ELEM; k++) el[k] = (k == 1) ? 4'd15 : 4'd0;
    run_frame(el, 1'b0, 0, 1'b0, acc);
  endtask

  task automatic test_backpressure();
    frame_t el;
    int acc;
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'($urandom);
    run_frame(el, 1'b0, 10, 1'b1, acc);
  endtask

  task automatic test_frame_err();
    frame_t el;
    int acc;
    int c0 = civ_count;
    int e0 = ferr_count;
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'($urandom);
    send_frame(el, 10, 9, 1'b0, acc);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ferr_count - e0 !== 1 || civ_count !== c0 || bus.s_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL early_last: ferr_cycles=%0d issues=%0d s_ready=%b, required 1 0 1",
               ferr_count - e0, civ_count - c0, bus.s_ready);
    end
    send_frame(el, N_ELEM, -1, 1'b0, acc);
    repeat (2) @(negedge clk);
    n_checks++;
    if (ferr_count - e0 !== 2 || civ_count !== c0 || bus.r_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL missing_last: ferr_cycles=%0d issues=%0d r_valid=%b, required 2 0 0",
               ferr_count - e0, civ_count - c0, bus.r_valid);
    end
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'd1;
    run_frame(el, 1'b0, 0, 1'b0, acc);
  endtask

  task automatic test_timeout();
    frame_t el;
    int acc;
    core_en = 1'b0;
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'($urandom);
    run_frame(el, 1'b1, 2, 1'b0, acc);
    core_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    frame_t el;
    int acc;
    int guard = 0;
    int c0 = civ_count;
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'($urandom);
    send_frame(el, 20, -1, 1'b0, acc);
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_collect");
    repeat (3) @(negedge clk);
    n_checks++;
    if (civ_count !== c0) begin
      n_errors++;
      $display("FAIL aborted_issue: %0d pulses, required 0", civ_count - c0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'd15;
    run_frame(el, 1'b0, 0, 1'b0, acc);
    // Reset again while a result is being held
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'($urandom);
    send_frame(el, N_ELEM, N_ELEM - 1, 1'b0, acc);
    while (bus.r_valid !== 1'b1 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_hold");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.s_ready !== 1'b1 || bus.r_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL recover: s_ready=%b r_valid=%b, required 1 0", bus.s_ready, bus.r_valid);
    end
  endtask

  task automatic test_back_to_back();
    frame_t el;
    int acc_a;
    int acc_b;
    spur_en = 1'b1;
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'($urandom);
    run_frame(el, 1'b0, 0, 1'b0, acc_a);
    for (int k = 0; k < N_ELEM; k++) el[k] = 4'($urandom);
    run_frame(el, 1'b0, 0, 1'b0, acc_b);
    n_checks++;
    if (acc_b - acc_a !== 36) begin
      n_errors++;
      $display("FAIL frame_period: got %0d cycles, required 36", acc_b - acc_a);
    end
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < N_ELEM; k++) el[k] = 4'($urandom);
      run_frame(el, 1'b0, int'($urandom_range(0, 3)), f[0], acc_a);
    end
    spur_en = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.r_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_patterns();
    test_backpressure();
    test_frame_err();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
